seg_scan_decoder: RTL

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - two-digit multiplexed seven-segment scan decoder
// Samples seg/cs, rebuilds tens+units frames, tracks manual (dash) mode, staleness and errors.
module seg_scan_decoder #(
  parameter int DASH_LEN = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seg,
  input  logic [1:0] cs,
  output logic [6:0] value,
  output logic       frame_valid,
  output logic       value_changed,
  output logic       manual,
  output logic       stale,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int DW = $clog2(DASH_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DASH_MAX  = DW'(DASH_LEN);
  localparam logic [TW-1:0] STALE_MAX = TW'(TIMEOUT);

  typedef enum logic {WAIT_TENS, WAIT_UNITS} state_t;

  logic [7:0]    seg_q;
  logic [1:0]    cs_q;
  logic          primed_q;
  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [6:0]    value_q, value_d;
  logic          fv_q, fv_d;
  logic          vc_q, vc_d;
  logic          manual_q, manual_d;
  logic          stale_q, stale_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [DW-1:0] dash_q, dash_d;
  logic [TW-1:0] stale_cnt_q, stale_cnt_d;

  logic [3:0]    digit;
  logic          digit_ok;
  logic          is_dash;

  always_comb begin
    digit    = 4'd0;
    digit_ok = 1'b1;
    case (seg_q)
      8'b00000011: digit = 4'd0;
      8'b10011111: digit = 4'd1;
      8'b00100101: digit = 4'd2;
      8'b00001101: digit = 4'd3;
      8'b10011001: digit = 4'd4;
      8'b01001001: digit = 4'd5;
      8'b01000001: digit = 4'd6;
      8'b00011111: digit = 4'd7;
      8'b00000001: digit = 4'd8;
      8'b00001001: digit = 4'd9;
      default:     digit_ok = 1'b0;
    endcase
    is_dash = (seg_q == 8'b11111101);
  end

  always_comb begin
    state_d  = state_q;
    tens_d   = tens_q;
    value_d  = value_q;
    fv_d     = 1'b0;
    vc_d     = 1'b0;
    err_d    = 1'b0;
    manual_d = manual_q;
    dash_d   = dash_q;
    // The reset-loaded input registers hold no real sample, so the first post-reset edge decodes nothing.
    if (primed_q) begin
      case (cs_q)
        2'b10: begin
          dash_d = '0;
          if (digit_ok) begin
            tens_d  = digit;
            state_d = WAIT_UNITS;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_TENS;
          end
        end
        2'b01: begin
          dash_d = '0;
          if (!digit_ok) begin
            err_d   = 1'b1;
            state_d = WAIT_TENS;
          end else if (state_q == WAIT_TENS) begin
            err_d = 1'b1;
          end else begin
            value_d  = 7'(tens_q) * 7'd10 + 7'(digit);
            fv_d     = 1'b1;
            vc_d     = (value_d != value_q);
            manual_d = 1'b0;
            state_d  = WAIT_TENS;
          end
        end
        2'b11: begin
          state_d = WAIT_TENS;
          if (is_dash) begin
            if (dash_q != DASH_MAX) dash_d = dash_q + DW'(1);
            if (dash_d == DASH_MAX) manual_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            dash_d = '0;
          end
        end
        default: begin
          dash_d  = '0;
          err_d   = 1'b1;
          state_d = WAIT_TENS;
        end
      endcase
    end

    err_cnt_d = err_cnt_q;
    if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;

    stale_cnt_d = stale_cnt_q;
    if (fv_d) stale_cnt_d = '0;
    else if (stale_cnt_q != STALE_MAX) stale_cnt_d = stale_cnt_q + TW'(1);
    stale_d = (stale_cnt_d == STALE_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q       <= 8'hFF;
      cs_q        <= 2'b11;
      primed_q    <= 1'b0;
      state_q     <= WAIT_TENS;
      tens_q      <= 4'd0;
      value_q     <= 7'd0;
      fv_q        <= 1'b0;
      vc_q        <= 1'b0;
      manual_q    <= 1'b0;
      stale_q     <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
      dash_q      <= '0;
      stale_cnt_q <= '0;
    end else begin
      seg_q       <= seg;
      cs_q        <= cs;
      primed_q    <= 1'b1;
      state_q     <= state_d;
      tens_q      <= tens_d;
      value_q     <= value_d;
      fv_q        <= fv_d;
      vc_q        <= vc_d;
      manual_q    <= manual_d;
      stale_q     <= stale_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      dash_q      <= dash_d;
      stale_cnt_q <= stale_cnt_d;
    end
  end

  assign value         = value_q;
  assign frame_valid   = fv_q;
  assign value_changed = vc_q;
  assign manual        = manual_q;
  assign stale         = stale_q;
  assign err           = err_q;
  assign err_cnt       = err_cnt_q;

endmodule
